// File: rtl/mfp_lcd_ctrl.sv
// PCD8544 (Nokia 5110) sequencer: LCD reset pulse, init list, host bytes
// and full-frame refresh from a frame-buffer port, paced by serializer ce.
//
// Ports:
//   clk, i_rst_n           clock, async active-low reset
//   backlight              passed through to spi_ctrl[1]
//   refresh                frame refresh request pulse (sticky)
//   cmd_valid/dc/data      host byte in; cmd_ready = accepted this cycle
//   fb_rd/fb_addr/fb_data  frame-buffer read port (data one cycle later)
//   spi_value/ctrl/send    serializer byte, {rst_n,backlight,dc}, strobe
//   spi_ce                 serializer idle
//   busy, frame_done       status
module mfp_lcd_ctrl #(
  parameter int          RST_CYCLES = 16,
  parameter logic [6:0]  CONTRAST   = 7'h31,
  parameter int          FB_BYTES   = 504
) (
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic       backlight,
  input  logic       refresh,
  input  logic       cmd_valid,
  input  logic       cmd_dc,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic       fb_rd,
  output logic [8:0] fb_addr,
  input  logic [7:0] fb_data,
  output logic [7:0] spi_value,
  output logic [2:0] spi_ctrl,
  output logic       spi_send,
  input  logic       spi_ce,
  output logic       busy,
  output logic       frame_done
);

  localparam int CW = $clog2(RST_CYCLES + 1);

  typedef enum logic [2:0] {
    S_RST, S_INIT, S_IDLE, S_HOST,
    S_HDR, S_FETCH, S_CAPT, S_DATA
  } state_t;

  typedef enum logic [1:0] {
    B_ARM, B_SEND, B_WLO, B_WHI
  } bph_t;

  state_t        r_state;
  bph_t          r_bph;
  logic [2:0]    r_idx;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_value;
  logic          r_dc;
  logic          r_lrst;
  logic          r_send;
  logic          r_fb_rd;
  logic [8:0]    r_fb_addr;
  logic          r_done;
  logic          r_ref;
  logic [7:0]    r_hbyte;
  logic          r_hdc;

  logic [7:0] w_init;
  logic [7:0] w_byte;
  logic       w_dc;
  logic       w_eng;
  logic       w_bdone;
  logic       w_last;
  logic       w_take;

  always_comb begin
    w_init = 8'h21;
    unique case (r_idx)
      3'd0:    w_init = 8'h21;
      3'd1:    w_init = {1'b1, CONTRAST};
      3'd2:    w_init = 8'h04;
      3'd3:    w_init = 8'h14;
      3'd4:    w_init = 8'h20;
      default: w_init = 8'h0C;
    endcase
  end

  // Byte source for the engine; frame data is already in r_value.
  always_comb begin
    w_byte = r_value;
    w_dc   = r_dc;
    unique case (1'b1)
      r_state == S_INIT: begin
        w_byte = w_init;
        w_dc   = 1'b0;
      end
      r_state == S_HOST: begin
        w_byte = r_hbyte;
        w_dc   = r_hdc;
      end
      r_state == S_HDR: begin
        w_byte = r_idx[0] ? 8'h40 : 8'h80;
        w_dc   = 1'b0;
      end
      default: ;
    endcase
  end

  assign w_eng   = (r_state == S_INIT) || (r_state == S_HOST) ||
                   (r_state == S_HDR)  || (r_state == S_DATA);
  assign w_bdone = w_eng && (r_bph == B_WHI) && spi_ce;
  assign w_last  = (r_fb_addr == 9'(FB_BYTES - 1));
  assign w_take  = (r_state == S_IDLE) && !cmd_valid && r_ref;

  assign cmd_ready  = (r_state == S_IDLE) && cmd_valid;
  assign busy       = (r_state != S_IDLE);
  assign spi_ctrl   = {r_lrst, backlight, r_dc};
  assign spi_value  = r_value;
  assign spi_send   = r_send;
  assign fb_rd      = r_fb_rd;
  assign fb_addr    = r_fb_addr;
  assign frame_done = r_done;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_RST;
      r_bph     <= B_ARM;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_value   <= '0;
      r_dc      <= 1'b0;
      r_lrst    <= 1'b0;
      r_send    <= 1'b0;
      r_fb_rd   <= 1'b0;
      r_fb_addr <= '0;
      r_done    <= 1'b0;
      r_ref     <= 1'b0;
      r_hbyte   <= '0;
      r_hdc     <= 1'b0;
    end else begin
      r_send  <= 1'b0;
      r_done  <= 1'b0;
      r_fb_rd <= 1'b0;
      // A pulse coinciding with the frame start queues another frame.
      r_ref   <= refresh | (r_ref & ~w_take);

      if (w_eng) begin
        unique case (r_bph)
          B_ARM: if (spi_ce) begin
            r_value <= w_byte;
            r_dc    <= w_dc;
            r_send  <= 1'b1;
            r_bph   <= B_SEND;
          end
          B_SEND: r_bph <= B_WLO;
          B_WLO:  if (!spi_ce) r_bph <= B_WHI;
          B_WHI:  if (spi_ce) r_bph <= B_ARM;
        endcase
      end

      unique case (r_state)
        S_RST: begin
          if (r_cnt == CW'(RST_CYCLES - 1)) begin
            r_lrst  <= 1'b1;
            r_idx   <= '0;
            r_state <= S_INIT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_INIT: begin
          if (w_bdone) begin
            if (r_idx == 3'd5) begin
              r_idx   <= '0;
              r_state <= S_IDLE;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        S_IDLE: begin
          if (cmd_valid) begin
            r_hbyte <= cmd_data;
            r_hdc   <= cmd_dc;
            r_state <= S_HOST;
          end else if (r_ref) begin
            r_idx   <= '0;
            r_state <= S_HDR;
          end
        end
        S_HOST: begin
          if (w_bdone) r_state <= S_IDLE;
        end
        S_HDR: begin
          if (w_bdone) begin
            if (r_idx[0]) begin
              r_idx     <= '0;
              r_fb_addr <= '0;
              r_fb_rd   <= 1'b1;
              r_state   <= S_FETCH;
            end else begin
              r_idx <= 3'd1;
            end
          end
        end
        S_FETCH: r_state <= S_CAPT;
        S_CAPT: begin
          r_value <= fb_data;
          r_dc    <= 1'b1;
          r_state <= S_DATA;
        end
        S_DATA: begin
          if (w_bdone) begin
            if (w_last) begin
              r_done    <= 1'b1;
              r_fb_addr <= '0;
              r_state   <= S_IDLE;
            end else begin
              r_fb_addr <= r_fb_addr + 1'b1;
              r_fb_rd   <= 1'b1;
              r_state   <= S_FETCH;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mfp_lcd_ctrl.sv
// Bench for mfp_lcd_ctrl: serializer and frame-buffer models,
// scoreboard of expected {dc,byte} sends, directed steps.
module tb_mfp_lcd_ctrl;

  logic       clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       backlight = 1'b0;
  logic       refresh = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_dc = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready;
  logic       fb_rd;
  logic [8:0] fb_addr;
  logic [7:0] fb_data = 8'h00;
  logic [7:0] spi_value;
  logic [2:0] spi_ctrl;
  logic       spi_send;
  logic       spi_ce;
  logic       busy;
  logic       frame_done;

  int n_vec = 0;
  int n_err = 0;
  int n_send = 0;
  int n_done = 0;
  int exp_addr = 0;
  logic [8:0] exp_q[$];
  logic [8:0] e;

  logic       hold = 1'b0;
  logic [3:0] bcnt;

  always #5 clk = ~clk;

  mfp_lcd_ctrl #(
    .RST_CYCLES(16), .CONTRAST(7'h31), .FB_BYTES(504)
  ) dut (
    .clk(clk), .i_rst_n(i_rst_n), .backlight(backlight),
    .refresh(refresh), .cmd_valid(cmd_valid), .cmd_dc(cmd_dc),
    .cmd_data(cmd_data), .cmd_ready(cmd_ready), .fb_rd(fb_rd),
    .fb_addr(fb_addr), .fb_data(fb_data), .spi_value(spi_value),
    .spi_ctrl(spi_ctrl), .spi_send(spi_send), .spi_ce(spi_ce),
    .busy(busy), .frame_done(frame_done)
  );

  // Serializer: busy for a few cycles per byte; hold keeps it busy.
  always @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      spi_ce <= 1'b1;
      bcnt   <= '0;
    end else if (spi_send) begin
      spi_ce <= 1'b0;
      bcnt   <= 4'd4;
    end else if (bcnt != 0) begin
      bcnt <= bcnt - 1'b1;
    end else if (!hold) begin
      spi_ce <= 1'b1;
    end
  end

  always @(posedge clk) if (fb_rd) fb_data <= fb_addr[7:0];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (i_rst_n) begin
      if (spi_send) begin
        n_send++;
        chk("send_ce", 32'(spi_ce), 32'd1);
        chk("send_q", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("send_byte", 32'({spi_ctrl[2], spi_ctrl[0], spi_value}),
              32'({1'b1, e}));
        end
      end
      if (fb_rd) begin
        chk("fb_addr", 32'(fb_addr), 32'(exp_addr));
        exp_addr = (exp_addr == 503) ? 0 : exp_addr + 1;
      end
      if (frame_done) n_done++;
    end
  end

  task automatic push_init();
    exp_q.push_back(9'h021);
    exp_q.push_back(9'h0B1);
    exp_q.push_back(9'h004);
    exp_q.push_back(9'h014);
    exp_q.push_back(9'h020);
    exp_q.push_back(9'h00C);
  endtask

  task automatic push_frame();
    exp_q.push_back(9'h080);
    exp_q.push_back(9'h040);
    for (int i = 0; i < 504; i++) begin
      logic [8:0] a;
      a = 9'(i);
      exp_q.push_back({1'b1, a[7:0]});
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_frames(input string tag, input int tgt);
    int k;
    k = 0;
    while (n_done < tgt && k < 20000) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk(tag, 32'(n_done), 32'(tgt));
  endtask

  // Called at a negedge; asserts reset shortly after it.
  task automatic do_reset();
    int lowc;
    #2 i_rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_addr = 0;
    chk("rst_value", 32'(spi_value), 32'h0);
    chk("rst_ctrl", 32'(spi_ctrl), 32'({1'b0, backlight, 1'b0}));
    chk("rst_strobes", 32'({spi_send, cmd_ready, fb_rd, frame_done}), 32'h0);
    chk("rst_addr", 32'(fb_addr), 32'h0);
    chk("rst_busy", 32'(busy), 32'd1);
    repeat (3) @(negedge clk);
    i_rst_n = 1'b1;
    push_init();
    lowc = 0;
    while (!spi_ctrl[2] && lowc < 100) begin
      lowc++;
      @(negedge clk);
    end
    chk("rst_pulse", 32'(lowc), 32'd16);
    chk("init_busy", 32'(busy), 32'd1);
  endtask

  initial begin
    int snap;
    int k;

    // 1: reset pulse and init list
    repeat (2) @(negedge clk);
    do_reset();
    wait_idle("init_idle", 2000);
    chk("init_q", 32'(exp_q.size()), 32'd0);

    // 2: single host data byte
    backlight = 1'b1;
    @(negedge clk);
    #1 chk("backlight", 32'(spi_ctrl[1]), 32'd1);
    cmd_valid = 1'b1;
    cmd_dc    = 1'b1;
    cmd_data  = 8'hA5;
    exp_q.push_back(9'h1A5);
    #1 chk("host_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 chk("host_ready_1cyc", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b0;
    wait_idle("host_idle", 200);
    chk("host_q", 32'(exp_q.size()), 32'd0);

    // 3: one frame refresh
    @(negedge clk);
    refresh = 1'b1;
    push_frame();
    @(negedge clk);
    refresh = 1'b0;
    wait_frames("frame1", 1);
    wait_idle("frame1_idle", 200);
    chk("frame1_q", 32'(exp_q.size()), 32'd0);
    repeat (50) @(negedge clk);
    chk("frame1_once", 32'(n_done), 32'd1);

    // 4: host and refresh together, then refresh mid-frame
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_dc    = 1'b0;
    cmd_data  = 8'h55;
    refresh   = 1'b1;
    exp_q.push_back(9'h055);
    push_frame();
    #1 chk("prio_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    refresh   = 1'b0;
    k = 0;
    while (!(fb_rd && fb_addr == 9'd200) && k < 10000) begin
      @(negedge clk);
      k++;
    end
    chk("mid_reach", 32'(fb_addr), 32'd200);
    refresh = 1'b1;
    push_frame();
    @(negedge clk);
    refresh = 1'b0;
    wait_frames("frame3", 3);
    wait_idle("frame3_idle", 200);
    chk("frame3_q", 32'(exp_q.size()), 32'd0);
    repeat (200) @(negedge clk);
    chk("frame3_only", 32'(n_done), 32'd3);

    // 5: reset in the middle of a frame
    @(negedge clk);
    refresh = 1'b1;
    push_frame();
    @(negedge clk);
    refresh = 1'b0;
    k = 0;
    while (!(fb_rd && fb_addr == 9'd100) && k < 10000) begin
      @(negedge clk);
      k++;
    end
    chk("rst_reach", 32'(fb_addr), 32'd100);
    do_reset();
    wait_idle("reinit_idle", 2000);
    chk("reinit_q", 32'(exp_q.size()), 32'd0);
    snap = n_send;
    repeat (300) @(negedge clk);
    chk("no_frame", 32'(n_send), 32'(snap));
    chk("no_frame_busy", 32'(busy), 32'd0);

    // 6: serializer stalls after a send
    hold = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_dc    = 1'b0;
    cmd_data  = 8'h3C;
    exp_q.push_back(9'h03C);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_data  = 8'h7E;
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("stall_sent", 32'(exp_q.size()), 32'd0);
    snap = n_send;
    repeat (1000) @(negedge clk);
    chk("stall_nosend", 32'(n_send), 32'(snap));
    chk("stall_busy", 32'(busy), 32'd1);
    chk("stall_ce", 32'(spi_ce), 32'd0);
    hold = 1'b0;
    wait_idle("stall_idle", 100);
    @(negedge clk);
    cmd_valid = 1'b1;
    exp_q.push_back(9'h07E);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_idle("resume_idle", 200);
    chk("resume_q", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
